// File: rtl/tppe_pkg.sv
// Shared tppe scheduler types: FSM state encoding and a state-class helper.
package tppe_pkg;

   localparam int SCHED_STATE_W = 3;

   typedef enum logic [SCHED_STATE_W-1:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FETCH = 3'd2,
      WAITD = 3'd3,
      ISSUE = 3'd4,
      ACC   = 3'd5,
      LIF   = 3'd6,
      NEXT  = 3'd7
   } sched_state_t;

   // States that wait on an external party and are therefore watched for timeout
   function automatic logic is_wait_state(input sched_state_t s);
      return (s == WAITD) || (s == ISSUE) || (s == ACC) || (s == LIF);
   endfunction

endpackage

// File: rtl/tppe_tile_scheduler_if.sv
// Bundle of control, tile-buffer and tppe signals around the tile scheduler.
// master = scheduler side, slave = environment (control, tile buffer, tppe).
interface tppe_tile_scheduler_if #(
   parameter int TIMESTEPS      = 4,
   parameter int TILE_IDX_WIDTH = 8
);
   logic                      start;
   logic [TILE_IDX_WIDTH-1:0] num_tiles;
   logic                      busy;
   logic                      done;
   logic [TILE_IDX_WIDTH-1:0] tile_addr;
   logic                      tile_rd_en;
   logic                      tile_valid;
   logic                      tppe_rst_fast;
   logic                      tppe_rst_slow;
   logic                      tppe_rst_accum;
   logic                      tppe_rst_lif;
   logic                      tppe_valid;
   logic                      tppe_ready;
   logic                      tppe_res_valid;
   logic                      tppe_lif_done;
   logic [TIMESTEPS-1:0]      tppe_spikes;
   logic [TIMESTEPS-1:0]      spike_out;
   logic                      spike_valid;
   logic [TILE_IDX_WIDTH-1:0] spike_tile;
   logic                      wdog_err;

   modport master (
      input  start, num_tiles, tile_valid, tppe_ready, tppe_res_valid,
             tppe_lif_done, tppe_spikes,
      output busy, done, tile_addr, tile_rd_en, tppe_rst_fast, tppe_rst_slow,
             tppe_rst_accum, tppe_rst_lif, tppe_valid, spike_out, spike_valid,
             spike_tile, wdog_err
   );

   modport slave (
      output start, num_tiles, tile_valid, tppe_ready, tppe_res_valid,
             tppe_lif_done, tppe_spikes,
      input  busy, done, tile_addr, tile_rd_en, tppe_rst_fast, tppe_rst_slow,
             tppe_rst_accum, tppe_rst_lif, tppe_valid, spike_out, spike_valid,
             spike_tile, wdog_err
   );
endinterface

// File: rtl/tppe_sched_wdog.sv
// Per-wait-state timeout counter for the tile scheduler; only built when
// TPPE_SCHED_WDOG_EN is defined. expire is high while the counter is all-ones.
`ifdef TPPE_SCHED_WDOG_EN
module tppe_sched_wdog #(
   parameter int WDOG_WIDTH = 12
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expire
);
   localparam logic [WDOG_WIDTH-1:0] CNT_ONE = WDOG_WIDTH'(1);

   logic [WDOG_WIDTH-1:0] cnt_r;

   // Timeout counter: cleared on wait-state entry, counts while waiting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (inc) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = (cnt_r == '1);
endmodule
`endif

// File: rtl/tppe_tile_scheduler.sv
// Sequences one tppe over a run of bitmask tiles: clear, fetch, issue, collect spikes.
// Optional tile watchdog enabled by defining TPPE_SCHED_WDOG_EN.
module tppe_tile_scheduler
   import tppe_pkg::*;
#(
   parameter int TIMESTEPS      = 4,
   parameter int TILE_IDX_WIDTH = 8,
   parameter int CLEAR_CYCLES   = 2,
   parameter int WDOG_WIDTH     = 12
) (
   input logic                   clk,
   input logic                   rst,
   tppe_tile_scheduler_if.master bus
);
   localparam int                        CLR_CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam logic [CLR_CNT_W-1:0]      CLR_LAST  = CLR_CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CLR_CNT_W-1:0]      CLR_ONE   = CLR_CNT_W'(1);
   localparam logic [TILE_IDX_WIDTH-1:0] IDX_ONE   = TILE_IDX_WIDTH'(1);

   sched_state_t              state_r, state_next_s;
   logic [TILE_IDX_WIDTH-1:0] count_r, idx_r;
   logic [CLR_CNT_W-1:0]      clr_cnt_r;
   logic                      start_go_s, start_zero_s, last_tile_s, clr_done_s;
   logic                      spike_take_s, wdog_expire_s;

   logic                      busy_r, done_r, tile_rd_en_r, rst_hold_r, tppe_valid_r;
   logic                      spike_valid_r, wdog_err_r;
   logic [TILE_IDX_WIDTH-1:0] tile_addr_r, spike_tile_r;
   logic [TIMESTEPS-1:0]      spike_out_r;
   logic                      busy_s, done_s, tile_rd_en_s, rst_hold_s, tppe_valid_s;
   logic                      spike_valid_s, wdog_err_s;
   logic [TILE_IDX_WIDTH-1:0] tile_addr_s, spike_tile_s;
   logic [TIMESTEPS-1:0]      spike_out_s;

   assign start_go_s   = (state_r == IDLE) && bus.start && (bus.num_tiles != '0);
   assign start_zero_s = (state_r == IDLE) && bus.start && (bus.num_tiles == '0);
   assign last_tile_s  = (idx_r == (count_r - IDX_ONE));
   assign clr_done_s   = (clr_cnt_r == CLR_LAST);
   // Result and LIF arriving together in ACC are both taken in one go
   assign spike_take_s = bus.tppe_lif_done &&
                         ((state_r == LIF) || ((state_r == ACC) && bus.tppe_res_valid));

`ifdef TPPE_SCHED_WDOG_EN
   logic wdog_clr_s, wdog_inc_s;

   assign wdog_clr_s = is_wait_state(state_next_s) && (state_next_s != state_r);
   assign wdog_inc_s = is_wait_state(state_r);

   tppe_sched_wdog #(.WDOG_WIDTH(WDOG_WIDTH)) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (wdog_clr_s),
      .inc    (wdog_inc_s),
      .expire (wdog_expire_s)
   );
`else
   localparam int wdog_width_unused = WDOG_WIDTH;
   assign wdog_expire_s = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; real progress always beats a coincident timeout
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:  if (start_go_s) state_next_s = CLEAR; else state_next_s = IDLE;
         CLEAR: if (clr_done_s) state_next_s = FETCH; else state_next_s = CLEAR;
         FETCH: state_next_s = WAITD;
         WAITD: begin
            if (bus.tile_valid)      state_next_s = ISSUE;
            else if (wdog_expire_s)  state_next_s = NEXT;
            else                     state_next_s = WAITD;
         end
         ISSUE: begin
            if (bus.tppe_ready)      state_next_s = ACC;
            else if (wdog_expire_s)  state_next_s = NEXT;
            else                     state_next_s = ISSUE;
         end
         ACC: begin
            if (spike_take_s)            state_next_s = NEXT;
            else if (bus.tppe_res_valid) state_next_s = LIF;
            else if (wdog_expire_s)      state_next_s = NEXT;
            else                         state_next_s = ACC;
         end
         LIF: begin
            if (spike_take_s)        state_next_s = NEXT;
            else if (wdog_expire_s)  state_next_s = NEXT;
            else                     state_next_s = LIF;
         end
         NEXT:  if (last_tile_s) state_next_s = IDLE; else state_next_s = CLEAR;
         default: state_next_s = IDLE;
      endcase
   end

   // FSM outputs, decoded from the upcoming state so the registers line up with it
   always_comb begin
      busy_s        = (state_next_s != IDLE);
      done_s        = start_zero_s || ((state_r == NEXT) && last_tile_s);
      tile_rd_en_s  = (state_next_s == FETCH);
      rst_hold_s    = (state_next_s == IDLE) || (state_next_s == CLEAR);
      tppe_valid_s  = (state_next_s == ISSUE);
      spike_valid_s = spike_take_s;
      if (state_next_s == FETCH) begin
         tile_addr_s = idx_r;
      end else begin
         tile_addr_s = tile_addr_r;
      end
      if (spike_take_s) begin
         spike_out_s  = bus.tppe_spikes;
         spike_tile_s = idx_r;
      end else begin
         spike_out_s  = spike_out_r;
         spike_tile_s = spike_tile_r;
      end
`ifdef TPPE_SCHED_WDOG_EN
      if ((state_r == IDLE) && bus.start) begin
         wdog_err_s = 1'b0;
      end else if (wdog_expire_s && is_wait_state(state_r) &&
                   (state_next_s == NEXT) && !spike_take_s) begin
         wdog_err_s = 1'b1;
      end else begin
         wdog_err_s = wdog_err_r;
      end
`else
      wdog_err_s = 1'b0;
`endif
   end

   // Output registers; tppe is held in clear out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         tile_rd_en_r  <= 1'b0;
         rst_hold_r    <= 1'b1;
         tppe_valid_r  <= 1'b0;
         spike_valid_r <= 1'b0;
         wdog_err_r    <= 1'b0;
         tile_addr_r   <= '0;
         spike_tile_r  <= '0;
         spike_out_r   <= '0;
      end else begin
         busy_r        <= busy_s;
         done_r        <= done_s;
         tile_rd_en_r  <= tile_rd_en_s;
         rst_hold_r    <= rst_hold_s;
         tppe_valid_r  <= tppe_valid_s;
         spike_valid_r <= spike_valid_s;
         wdog_err_r    <= wdog_err_s;
         tile_addr_r   <= tile_addr_s;
         spike_tile_r  <= spike_tile_s;
         spike_out_r   <= spike_out_s;
      end
   end

   // Run bookkeeping: tile count, current index, clear-pulse length
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r   <= '0;
         idx_r     <= '0;
         clr_cnt_r <= '0;
      end else begin
         if (start_go_s) begin
            count_r <= bus.num_tiles;
            idx_r   <= '0;
         end else if ((state_r == NEXT) && !last_tile_s) begin
            idx_r   <= idx_r + IDX_ONE;
         end
         if (state_r == CLEAR) begin
            clr_cnt_r <= clr_cnt_r + CLR_ONE;
         end else begin
            clr_cnt_r <= '0;
         end
      end
   end

   assign bus.busy           = busy_r;
   assign bus.done           = done_r;
   assign bus.tile_addr      = tile_addr_r;
   assign bus.tile_rd_en     = tile_rd_en_r;
   assign bus.tppe_rst_fast  = rst_hold_r;
   assign bus.tppe_rst_slow  = rst_hold_r;
   assign bus.tppe_rst_accum = rst_hold_r;
   assign bus.tppe_rst_lif   = rst_hold_r;
   assign bus.tppe_valid     = tppe_valid_r;
   assign bus.spike_out      = spike_out_r;
   assign bus.spike_valid    = spike_valid_r;
   assign bus.spike_tile     = spike_tile_r;
   assign bus.wdog_err       = wdog_err_r;
endmodule
